// File: rtl/cmp_share_arb_if.sv
// Request/operand/result bundle between the requesters and the shared-comparator arbiter.
// The master side is the requester cluster; the slave side is the arbiter.
interface cmp_share_arb_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] a_bus;
    logic [N*W-1:0] b_bus;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           res_eq;
    logic           res_gt;
    logic           res_lt;
    logic           busy;

    modport master (
        output req, a_bus, b_bus,
        input  gnt, done, res_eq, res_gt, res_lt, busy
    );

    modport slave (
        input  req, a_bus, b_bus,
        output gnt, done, res_eq, res_gt, res_lt, busy
    );
endinterface

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter that time-shares one magnitude comparator among N requesters.
// One compare every three cycles: IDLE picks and latches, GRANT compares, RESULT reports.
module comparator #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         AequalB,
    output logic         greater,
    output logic         lesser
);
    assign AequalB = (A == B);
    assign greater = (A > B);
    assign lesser  = (A < B);
endmodule

// state   | meaning
// IDLE    | scan req from ptr, latch winner operands
// GRANT   | gnt high, comparator evaluates latched operands
// RESULT  | done high, res_* valid, advance ptr
module cmp_share_arb #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_share_arb_if.slave   bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  win_q, win_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           eq_q, eq_d;
    logic           gt_q, gt_d;
    logic           lt_q, lt_d;
    logic           busy_q, busy_d;

    logic           found;
    logic [PW-1:0]  pick;
    logic [PW-1:0]  cand;
    logic           cmp_eq, cmp_gt, cmp_lt;

    comparator #(.W(W)) u_cmp (
        .A       (op_a_q),
        .B       (op_b_q),
        .AequalB (cmp_eq),
        .greater (cmp_gt),
        .lesser  (cmp_lt)
    );

    // First set request at or after ptr, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        gnt_d   = '0;
        done_d  = '0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d       = pick;
                    op_a_d      = bus.a_bus[int'(pick)*W +: W];
                    op_b_d      = bus.b_bus[int'(pick)*W +: W];
                    gnt_d[pick] = 1'b1;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                eq_d         = cmp_eq;
                gt_d         = cmp_gt;
                lt_d         = cmp_lt;
                done_d[win_q] = 1'b1;
                state_d      = S_RESULT;
            end
            S_RESULT: begin
                ptr_d   = (win_q == PW'(N-1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.res_eq = eq_q;
    assign bus.res_gt = gt_q;
    assign bus.res_lt = lt_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_cmp_share_arb.sv
// Bench for cmp_share_arb: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cmp_share_arb;
    localparam int N = 4;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    cmp_share_arb_if #(.N(N), .W(W)) bus ();

    cmp_share_arb #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: schedules each service as a 3-edge transaction.
    int           m_edge      = 0;
    int           m_free      = 0;
    int           m_done_edge = -1;
    int           m_ptr       = 0;
    int           m_win       = 0;
    logic [W-1:0] m_opa, m_opb;
    logic [N-1:0] exp_gnt, exp_done;
    logic         exp_eq, exp_gt, exp_lt, exp_busy;
    bit           m_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ptr       = 0;
            m_free      = m_edge + 1;
            m_done_edge = -1;
            exp_gnt     = '0;
            exp_done    = '0;
            exp_eq      = 1'b0;
            exp_gt      = 1'b0;
            exp_lt      = 1'b0;
            exp_busy    = 1'b0;
        end else begin
            exp_gnt  = '0;
            exp_done = '0;
            exp_busy = 1'b0;
            if (m_edge == m_done_edge) begin
                int d;
                d        = int'(m_opa) - int'(m_opb);
                exp_done = N'(1) << m_win;
                exp_eq   = (d == 0);
                exp_gt   = (d > 0);
                exp_lt   = (d < 0);
                exp_busy = 1'b1;
            end else if (m_edge >= m_free && bus.req != '0) begin
                bit got;
                got = 0;
                for (int k = 0; k < N; k++) begin
                    if (!got && bus.req[(m_ptr + k) % N]) begin
                        got   = 1;
                        m_win = (m_ptr + k) % N;
                    end
                end
                m_opa       = bus.a_bus[m_win*W +: W];
                m_opb       = bus.b_bus[m_win*W +: W];
                exp_gnt     = N'(1) << m_win;
                exp_busy    = 1'b1;
                m_done_edge = m_edge + 1;
                m_free      = m_edge + 3;
                m_ptr       = (m_win + 1) % N;
            end
        end
        m_edge++;
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [11:0] act, expv;
            act  = {bus.gnt, bus.done, bus.res_eq, bus.res_gt, bus.res_lt, bus.busy};
            expv = {exp_gnt, exp_done, exp_eq, exp_gt, exp_lt, exp_busy};
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL model_cycle edge=%0d actual={gnt,done,eq,gt,lt,busy}=%b required=%b",
                         m_edge, act, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [2:0] res3();
        return {bus.res_eq, bus.res_gt, bus.res_lt};
    endfunction

    int last_gnt_edge = 0;

    task automatic wait_gnt(input logic [N-1:0] expv, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == '0 && n < 10);
        if (bus.gnt == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=gnt 0 after %0d cycles required=%b", name, n, expv);
        end else begin
            chk(name, 32'(bus.gnt), 32'(expv));
        end
        last_gnt_edge = m_edge;
    endtask

    initial begin
        int prev;
        logic [2:0] rot_res [4];
        rot_res[0] = 3'b001;
        rot_res[1] = 3'b001;
        rot_res[2] = 3'b100;
        rot_res[3] = 3'b010;

        rst_n     = 1'b0;
        bus.req   = '0;
        bus.a_bus = '0;
        bus.b_bus = '0;

        // Reset values
        tick();
        tick();
        chk("reset_outputs", 32'({bus.gnt, bus.done, res3(), bus.busy}), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", 32'({bus.gnt, bus.done, res3(), bus.busy}), 32'd0);

        // Single-requester sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.a_bus[3:0] = 4'(a);
                bus.b_bus[3:0] = 4'(b);
                bus.req        = 4'b0001;
                wait_gnt(4'b0001, "sweep_gnt");
                tick();
                chk("sweep_done", 32'(bus.done), 32'h1);
                if (a == 9 && b == 3)   chk("sweep_9_3",   32'(res3()), 32'b010);
                if (a == 15 && b == 15) chk("sweep_15_15", 32'(res3()), 32'b100);
                if (a == 0 && b == 1)   chk("sweep_0_1",   32'(res3()), 32'b001);
            end
        end
        bus.req = '0;
        tick();

        // Pointer back to 0 for the rotation scenario
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.a_bus[i*W +: W] = 4'(i);
            bus.b_bus[i*W +: W] = 4'd2;
        end
        bus.req = 4'b1111;
        prev = 0;
        for (int i = 0; i < N; i++) begin
            wait_gnt(4'(1 << i), "rot_gnt");
            if (i > 0) chk("rot_spacing", 32'(last_gnt_edge - prev), 32'd3);
            prev = last_gnt_edge;
            tick();
            chk("rot_done", 32'(bus.done), 32'(1 << i));
            chk("rot_res", 32'(res3()), 32'(rot_res[i]));
            if (i == N-1) bus.req = 4'b0101;
        end

        // Wrap after requester 3, then skip requester 1
        wait_gnt(4'b0001, "wrap_gnt");
        chk("wrap_spacing", 32'(last_gnt_edge - prev), 32'd3);
        tick();
        chk("wrap_done", 32'(bus.done), 32'b0001);
        chk("wrap_res", 32'(res3()), 32'b001);
        bus.req = 4'b0100;
        wait_gnt(4'b0100, "skip_gnt");
        tick();
        chk("skip_done", 32'(bus.done), 32'b0100);
        chk("skip_res", 32'(res3()), 32'b100);
        bus.req = '0;
        tick();

        // Operands and req change after grant
        bus.a_bus[1*W +: W] = 4'd5;
        bus.b_bus[1*W +: W] = 4'd7;
        bus.req = 4'b0010;
        wait_gnt(4'b0010, "late_gnt");
        bus.a_bus[1*W +: W] = 4'd15;
        bus.b_bus[1*W +: W] = 4'd0;
        bus.req = '0;
        tick();
        chk("late_done", 32'(bus.done), 32'b0010);
        chk("late_res", 32'(res3()), 32'b001);
        repeat (2) tick();

        // Reset during GRANT
        bus.a_bus[2*W +: W] = 4'd12;
        bus.b_bus[2*W +: W] = 4'd4;
        bus.req = 4'b0100;
        wait_gnt(4'b0100, "rst_mid_gnt");
        rst_n = 1'b0;
        tick();
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_res", 32'(res3()), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        bus.a_bus[3:0] = 4'd0;
        bus.b_bus[3:0] = 4'd2;
        bus.req = 4'b1111;
        wait_gnt(4'b0001, "post_rst_gnt");
        tick();
        chk("post_rst_done", 32'(bus.done), 32'b0001);
        bus.req = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
